d_reg_pipe: RTL and testbench
=============================

// Module: d_reg_pipe
// PURPOSE
//   Parametrised successor to the single-bit async-reset D flip-flop.
//   WIDTH-bit, DEPTH-stage register pipeline with global stall, per-stage valid tracking,
//   synchronous clear, programmable reset value and complementary outputs (q/qb).
//   Used as a retiming/delay line between datapath blocks; DEPTH=1 gives a plain WIDTH-bit DFF with enable.
// PARAMETERS
//   WIDTH    8   data width in bits (>=1)
//   DEPTH    3   number of register stages (>=1); latency in enabled cycles
//   RST_VAL  0   WIDTH-bit value loaded into every data stage on reset/clear
// PORTS
//   clk          input   1               rising-edge clock
//   async_reset  input   1               asynchronous, active-low reset
//   en           input   1               1 = pipeline advances this edge; 0 = all stages hold
//   sync_clr     input   1               synchronous clear, same effect as reset, at the edge
//   d_valid      input   1               qualifies d; captured into stage 0 valid bit
//   d            input   WIDTH           input data
//   q            output  WIDTH           last-stage data
//   qb           output  WIDTH           bitwise complement of q, always exactly ~q
//   q_valid      output  1               valid bit of last stage
//   occ          output  $clog2(DEPTH+1) count of stages currently holding valid data (0..DEPTH)
// BEHAVIOUR
//   - Storage: data[0..DEPTH-1] (WIDTH each), vld[0..DEPTH-1], occ counter; all flops.
//   - async_reset=0: immediately, independent of clk:
//     - data[i]=RST_VAL, vld[i]=0, occ=0;
//     - hence q=RST_VAL, qb=~RST_VAL, q_valid=0.
//     - Held while low; first active edge is the first rising clk with async_reset=1.
//   - Priority at each rising clk (async_reset=1): sync_clr > en > hold.
//     - sync_clr=1: same state as reset, regardless of en/d/d_valid.
//     - en=1: data[0]<=d, vld[0]<=d_valid; data[i]<=data[i-1], vld[i]<=vld[i-1] for i>=1.
//     - en=0: every data/vld/occ flop holds; d and d_valid ignored (input dropped, no backpressure).
//   - q=data[DEPTH-1], q_valid=vld[DEPTH-1], qb=~data[DEPTH-1]. Outputs come directly from flops.
//     - No combinational path from d to q, even when DEPTH=1.
//   - Latency: a word applied with en=1 at edge k appears on q after edge k+DEPTH-1.
//     - Counted in enabled edges only; stalled edges add no shift.
//   - occ: on an en=1 edge, occ <= occ + d_valid - vld[DEPTH-1] (pre-edge values).
//     - Never wraps: range 0..DEPTH is guaranteed by construction.
//     - Cleared by reset and by sync_clr.
//     - Invariant: occ == popcount(vld) at all times.
//   - Invalid data still shifts: data stages shift regardless of d_valid; only vld marks meaning.
//   - Reset/clear mid-stream: all in-flight words are discarded; nothing is emitted afterwards.
//   - Async reset asserted in the same cycle as en/sync_clr: reset wins.
// TESTING
//   1. Reset: WIDTH=8, DEPTH=3, RST_VAL=8'hA5, async_reset low mid-cycle.
//      -> q=8'hA5, qb=8'h5A, q_valid=0, occ=0 before the next clk edge.
//   2. Stream: en=1, d_valid=1, d=01,02,03,04 on consecutive edges.
//      -> q=01 after the 3rd edge, then 02,03,04.
//      -> occ=1,2,3,3; q_valid rises after the 3rd edge.
//   3. Stall: after loading 11,22, hold en=0 for 4 edges with d=FF, d_valid=1.
//      -> all state and occ=2 frozen; FF never appears; resuming en=1 delivers 11 on the next enabled edge.
//   4. Bubbles: d_valid pattern 1,0,1 with d=10,20,30.
//      -> q_valid sequence 1,0,1 at output with q=10,20,30; occ tracks popcount(vld) every cycle.
//   5. Clear priority: pipeline full (occ=3), assert sync_clr and en with d_valid=1 on one edge.
//      -> q=RST_VAL, q_valid=0, occ=0 after that edge.
//   6. Reset mid-stream: DEPTH=1, pulse async_reset low between edges with occ=1.
//      -> outputs reset immediately.
//      -> Next en=1 edge with d=3C gives q=3C, qb=C3 (single-cycle latency).
//   All runs: assert qb==~q and occ==popcount(vld) every cycle.

Source files
------------

// File: rtl/d_reg_pipe_if.sv
// ============================================================================
// Module      : d_reg_pipe_if
// Description : Bus bundle for d_reg_pipe. Carries the stall/clear controls,
//               the qualified input word, and the q/qb/q_valid/occ outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface d_reg_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    localparam int c_OCC_W = $clog2(DEPTH + 1);

    logic               en;
    logic               sync_clr;
    logic               d_valid;
    logic [WIDTH-1:0]   d;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   qb;
    logic               q_valid;
    logic [c_OCC_W-1:0] occ;

    // Upstream side: drives controls and data, observes the pipeline output.
    modport master (
        output en, sync_clr, d_valid, d,
        input  q, qb, q_valid, occ
    );

    // Pipeline side.
    modport slave (
        input  en, sync_clr, d_valid, d,
        output q, qb, q_valid, occ
    );
endinterface

`default_nettype wire

// File: rtl/d_reg_pipe.sv
// ============================================================================
// Module      : d_reg_pipe
// Description : WIDTH-bit, DEPTH-stage register pipeline with global stall,
//               per-stage valid tracking, synchronous clear, programmable
//               reset value, complementary outputs and an occupancy count.
//               DEPTH=1 degenerates to a plain WIDTH-bit DFF with enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module d_reg_pipe #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire logic    clk,
    input  wire logic    async_reset,
    d_reg_pipe_if.slave  bus
);
    localparam int c_OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_data [DEPTH];
    logic [DEPTH-1:0]   r_vld;
    logic [c_OCC_W-1:0] r_occ;
    logic [c_OCC_W-1:0] w_occ_next;
    logic [DEPTH-1:0]   w_vld_shift;

    // Valid vector after one shift; a one-stage pipe just takes d_valid.
    if (DEPTH == 1) begin : g_vld_single
        assign w_vld_shift = bus.d_valid;
    end else begin : g_vld_multi
        assign w_vld_shift = {r_vld[DEPTH-2:0], bus.d_valid};
    end

    // Occupancy after an enabled edge: +1 for a valid word entering, -1 for one leaving.
    always_comb begin
        w_occ_next = r_occ;
        if (bus.d_valid && !r_vld[DEPTH-1]) begin
            w_occ_next = r_occ + c_OCC_W'(1);
        end else if (!bus.d_valid && r_vld[DEPTH-1]) begin
            w_occ_next = r_occ - c_OCC_W'(1);
        end
    end

    // Data stages: reset/clear load RST_VAL, enabled edges shift regardless of validity.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RST_VAL;
            end
        end else if (bus.sync_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RST_VAL;
            end
        end else if (bus.en) begin
            r_data[0] <= bus.d;
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i] <= r_data[i-1];
            end
        end
    end

    // Valid bits and occupancy move together so occ always equals popcount(r_vld).
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            r_vld <= '0;
            r_occ <= '0;
        end else if (bus.sync_clr) begin
            r_vld <= '0;
            r_occ <= '0;
        end else if (bus.en) begin
            r_vld <= w_vld_shift;
            r_occ <= w_occ_next;
        end
    end

    assign bus.q       = r_data[DEPTH-1];
    assign bus.qb      = ~r_data[DEPTH-1];
    assign bus.q_valid = r_vld[DEPTH-1];
    assign bus.occ     = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_d_reg_pipe.sv
// ============================================================================
// Module      : tb_d_reg_pipe
// Description : Self-checking bench for d_reg_pipe. Instance A is 8x3 with
//               RST_VAL=A5, instance B is 8x1 with RST_VAL=00. A queue of
//               stage entries (front = output stage) is the scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d_reg_pipe;
    typedef struct packed {
        logic [7:0] data;
        logic       v;
    } ent_t;

    logic clk = 1'b0;
    logic rst_a_n = 1'b1;
    logic rst_b_n = 1'b1;
    logic mon_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ent_t sb_a[$];
    ent_t sb_b[$];

    always #5 clk = ~clk;

    d_reg_pipe_if #(.WIDTH(8), .DEPTH(3)) ifa ();
    d_reg_pipe_if #(.WIDTH(8), .DEPTH(1)) ifb ();

    d_reg_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5)) u_a (
        .clk(clk), .async_reset(rst_a_n), .bus(ifa.slave)
    );
    d_reg_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00)) u_b (
        .clk(clk), .async_reset(rst_b_n), .bus(ifb.slave)
    );

    task automatic reset_model_a();
        sb_a.delete();
        for (int i = 0; i < 3; i++) sb_a.push_back('{data: 8'hA5, v: 1'b0});
    endtask

    task automatic reset_model_b();
        sb_b.delete();
        sb_b.push_back('{data: 8'h00, v: 1'b0});
    endtask

    function automatic int cnt_a();
        int n = 0;
        foreach (sb_a[i]) n += (sb_a[i].v === 1'b1) ? 1 : 0;
        return n;
    endfunction

    function automatic int cnt_b();
        int n = 0;
        foreach (sb_b[i]) n += (sb_b[i].v === 1'b1) ? 1 : 0;
        return n;
    endfunction

    // One clock on instance A; scoreboard advances as the stages would.
    task automatic cycle_a(input logic e, input logic c, input logic dv, input logic [7:0] dd);
        ifa.en = e; ifa.sync_clr = c; ifa.d_valid = dv; ifa.d = dd;
        @(posedge clk); #1;
        if (c) reset_model_a();
        else if (e) begin
            sb_a.delete(0);
            sb_a.push_back('{data: dd, v: dv});
        end
    endtask

    task automatic cycle_b(input logic e, input logic c, input logic dv, input logic [7:0] dd);
        ifb.en = e; ifb.sync_clr = c; ifb.d_valid = dv; ifb.d = dd;
        @(posedge clk); #1;
        if (c) reset_model_b();
        else if (e) begin
            sb_b.delete(0);
            sb_b.push_back('{data: dd, v: dv});
        end
    endtask

    // Every cycle: qb is ~q, and q/q_valid/occ match the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (ifa.qb !== ~ifa.q) begin
                errors++; $display("FAIL mon_qb_a: qb=%h required %h", ifa.qb, ~ifa.q);
            end
            checks++;
            if ({ifa.q, ifa.q_valid, ifa.occ} !== {sb_a[0].data, sb_a[0].v, 2'(cnt_a())}) begin
                errors++;
                $display("FAIL mon_a: q=%h v=%b occ=%0d required q=%h v=%b occ=%0d",
                         ifa.q, ifa.q_valid, ifa.occ, sb_a[0].data, sb_a[0].v, cnt_a());
            end
            checks++;
            if (ifb.qb !== ~ifb.q) begin
                errors++; $display("FAIL mon_qb_b: qb=%h required %h", ifb.qb, ~ifb.q);
            end
            checks++;
            if ({ifb.q, ifb.q_valid, ifb.occ} !== {sb_b[0].data, sb_b[0].v, 1'(cnt_b())}) begin
                errors++;
                $display("FAIL mon_b: q=%h v=%b occ=%0d required q=%h v=%b occ=%0d",
                         ifb.q, ifb.q_valid, ifb.occ, sb_b[0].data, sb_b[0].v, cnt_b());
            end
        end
    end

    task automatic test_reset();
        @(posedge clk); #2;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        reset_model_a(); reset_model_b();
        #1;
        checks++;
        if ({ifa.q, ifa.qb, ifa.q_valid, ifa.occ} !== {8'hA5, 8'h5A, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_a: q=%h qb=%h v=%b occ=%0d required A5 5A 0 0",
                     ifa.q, ifa.qb, ifa.q_valid, ifa.occ);
        end
        checks++;
        if ({ifb.q, ifb.qb, ifb.q_valid, ifb.occ} !== {8'h00, 8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_b: q=%h qb=%h v=%b occ=%0d required 00 FF 0 0",
                     ifb.q, ifb.qb, ifb.q_valid, ifb.occ);
        end
        #1;
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_stream();
        logic [7:0] eq [7] = '{8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        logic       ev [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] eo [7] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        for (int k = 0; k < 7; k++) begin
            if (k < 4) cycle_a(1'b1, 1'b0, 1'b1, 8'(k + 1));
            else       cycle_a(1'b1, 1'b0, 1'b0, 8'h00);
            checks++;
            if ({ifa.q, ifa.q_valid, ifa.occ} !== {eq[k], ev[k], eo[k]}) begin
                errors++;
                $display("FAIL stream[%0d]: q=%h v=%b occ=%0d required q=%h v=%b occ=%0d",
                         k, ifa.q, ifa.q_valid, ifa.occ, eq[k], ev[k], eo[k]);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] eq [3] = '{8'h11, 8'h22, 8'h33};
        logic       ev [3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0] eo [3] = '{2'd2, 2'd1, 2'd0};
        cycle_a(1'b1, 1'b0, 1'b1, 8'h11);
        cycle_a(1'b1, 1'b0, 1'b1, 8'h22);
        for (int k = 0; k < 4; k++) begin
            cycle_a(1'b0, 1'b0, 1'b1, 8'hFF);
            checks++;
            if ({ifa.q, ifa.q_valid, ifa.occ} !== {8'h00, 1'b0, 2'd2}) begin
                errors++;
                $display("FAIL stall[%0d]: q=%h v=%b occ=%0d required q=00 v=0 occ=2",
                         k, ifa.q, ifa.q_valid, ifa.occ);
            end
        end
        for (int k = 0; k < 3; k++) begin
            cycle_a(1'b1, 1'b0, 1'b0, (k == 0) ? 8'h33 : 8'h00);
            checks++;
            if ({ifa.q, ifa.q_valid, ifa.occ} !== {eq[k], ev[k], eo[k]}) begin
                errors++;
                $display("FAIL resume[%0d]: q=%h v=%b occ=%0d required q=%h v=%b occ=%0d",
                         k, ifa.q, ifa.q_valid, ifa.occ, eq[k], ev[k], eo[k]);
            end
        end
    endtask

    task automatic test_bubbles();
        logic [7:0] din [6] = '{8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 8'h00};
        logic       dvi [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] eq  [6] = '{8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 8'h00};
        logic       ev  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0] eo  [6] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0};
        for (int k = 0; k < 6; k++) begin
            cycle_a(1'b1, 1'b0, dvi[k], din[k]);
            checks++;
            if ({ifa.q, ifa.q_valid, ifa.occ} !== {eq[k], ev[k], eo[k]}) begin
                errors++;
                $display("FAIL bubbles[%0d]: q=%h v=%b occ=%0d required q=%h v=%b occ=%0d",
                         k, ifa.q, ifa.q_valid, ifa.occ, eq[k], ev[k], eo[k]);
            end
        end
    endtask

    task automatic test_clear_priority();
        logic [7:0] eq [3] = '{8'hA5, 8'hA5, 8'h00};
        cycle_a(1'b1, 1'b0, 1'b1, 8'hA1);
        cycle_a(1'b1, 1'b0, 1'b1, 8'hA2);
        cycle_a(1'b1, 1'b0, 1'b1, 8'hA3);
        checks++;
        if ({ifa.q, ifa.q_valid, ifa.occ} !== {8'hA1, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL full: q=%h v=%b occ=%0d required q=A1 v=1 occ=3",
                     ifa.q, ifa.q_valid, ifa.occ);
        end
        cycle_a(1'b1, 1'b1, 1'b1, 8'hEE);
        checks++;
        if ({ifa.q, ifa.qb, ifa.q_valid, ifa.occ} !== {8'hA5, 8'h5A, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL clear: q=%h qb=%h v=%b occ=%0d required A5 5A 0 0",
                     ifa.q, ifa.qb, ifa.q_valid, ifa.occ);
        end
        for (int k = 0; k < 3; k++) begin
            cycle_a(1'b1, 1'b0, 1'b0, 8'h00);
            checks++;
            if ({ifa.q, ifa.q_valid, ifa.occ} !== {eq[k], 1'b0, 2'd0}) begin
                errors++;
                $display("FAIL after_clear[%0d]: q=%h v=%b occ=%0d required q=%h v=0 occ=0",
                         k, ifa.q, ifa.q_valid, ifa.occ, eq[k]);
            end
        end
    endtask

    task automatic test_reset_hold();
        cycle_a(1'b1, 1'b0, 1'b1, 8'h42);
        ifa.en = 1'b1; ifa.sync_clr = 1'b0; ifa.d_valid = 1'b1; ifa.d = 8'h99;
        #1;
        rst_a_n = 1'b0;
        reset_model_a();
        @(posedge clk); #1;
        checks++;
        if ({ifa.q, ifa.q_valid, ifa.occ} !== {8'hA5, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_wins: q=%h v=%b occ=%0d required q=A5 v=0 occ=0",
                     ifa.q, ifa.q_valid, ifa.occ);
        end
        rst_a_n = 1'b1;
        ifa.en = 1'b0; ifa.d_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        cycle_b(1'b1, 1'b0, 1'b1, 8'h77);
        checks++;
        if ({ifb.q, ifb.qb, ifb.q_valid, ifb.occ} !== {8'h77, 8'h88, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b_load: q=%h qb=%h v=%b occ=%0d required 77 88 1 1",
                     ifb.q, ifb.qb, ifb.q_valid, ifb.occ);
        end
        #1;
        rst_b_n = 1'b0;
        reset_model_b();
        #1;
        checks++;
        if ({ifb.q, ifb.qb, ifb.q_valid, ifb.occ} !== {8'h00, 8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b_reset: q=%h qb=%h v=%b occ=%0d required 00 FF 0 0",
                     ifb.q, ifb.qb, ifb.q_valid, ifb.occ);
        end
        #1;
        rst_b_n = 1'b1;
        cycle_b(1'b0, 1'b0, 1'b1, 8'h55);
        checks++;
        if ({ifb.q, ifb.q_valid, ifb.occ} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b_hold: q=%h v=%b occ=%0d required 00 0 0",
                     ifb.q, ifb.q_valid, ifb.occ);
        end
        cycle_b(1'b1, 1'b0, 1'b1, 8'h3C);
        checks++;
        if ({ifb.q, ifb.qb, ifb.q_valid, ifb.occ} !== {8'h3C, 8'hC3, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b_single: q=%h qb=%h v=%b occ=%0d required 3C C3 1 1",
                     ifb.q, ifb.qb, ifb.q_valid, ifb.occ);
        end
        cycle_b(1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({ifb.q, ifb.q_valid, ifb.occ} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b_drain: q=%h v=%b occ=%0d required 00 0 0",
                     ifb.q, ifb.q_valid, ifb.occ);
        end
    endtask

    initial begin
        ifa.en = 1'b0; ifa.sync_clr = 1'b0; ifa.d_valid = 1'b0; ifa.d = 8'h00;
        ifb.en = 1'b0; ifb.sync_clr = 1'b0; ifb.d_valid = 1'b0; ifb.d = 8'h00;
        test_reset();
        test_stream();
        test_stall();
        test_bubbles();
        test_clear_priority();
        test_reset_hold();
        test_reset_midstream();
        @(posedge clk); #1;
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
